fb_rect_fill: RTL and testbench

- Rectangle-fill engine that writes a solid colour into the 214x160, 3-bit-per-pixel framebuffer.
- It drives the framebuffer's write port; the VGA scan-out stage reads the other port.
- It accepts one command over a valid/ready handshake, clips the rectangle to the framebuffer, then writes one pixel per clock in row-major order.
- It is the CPU's drawing primitive for clears and filled boxes.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/fb_clip.sv | 39 +++
 rtl/fb_rect_fill.sv | 156 +++++++++++++++
 tb/tb_fb_rect_fill.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Framebuffer geometry, pixel type and fill-engine state type shared by the
// drawing engines and the VGA scan-out.
package vga_pkg;

    localparam int FB_WIDTH  = 214;
    localparam int FB_HEIGHT = 160;
    localparam int FB_ADDR_W = 16;

    typedef logic [2:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } fill_state_t;

    // Multiply by a constant using shifts and adds only; with a constant k the
    // untaken terms fold away.
    function automatic logic [FB_ADDR_W-1:0] mul_const(input logic [7:0]           y,
                                                       input logic [FB_ADDR_W-1:0] k);
        logic [FB_ADDR_W-1:0] acc;
        acc = '0;
        for (int b = 0; b < FB_ADDR_W; b++) begin
            if (k[b]) acc = acc + ({{(FB_ADDR_W-8){1'b0}}, y} << b);
        end
        return acc;
    endfunction

endpackage

// File: rtl/fb_clip.sv
// Combinational clipper: trims a rectangle to the framebuffer and returns the
// clipped width/height and the linear address of its top-left pixel.
module fb_clip
    import vga_pkg::*;
#(
    parameter int FB_WIDTH  = vga_pkg::FB_WIDTH,
    parameter int FB_HEIGHT = vga_pkg::FB_HEIGHT,
    parameter int FB_ADDR_W = vga_pkg::FB_ADDR_W
) (
    input  logic [7:0]           i_x0,
    input  logic [7:0]           i_y0,
    input  logic [7:0]           i_w,
    input  logic [7:0]           i_h,
    output logic [7:0]           o_w_clip,
    output logic [7:0]           o_h_clip,
    output logic [FB_ADDR_W-1:0] o_row_start
);

    localparam logic [8:0] W_LIM = 9'(FB_WIDTH);
    localparam logic [8:0] H_LIM = 9'(FB_HEIGHT);

    logic [8:0] w_x_sum;
    logic [8:0] w_x_end;
    logic [8:0] w_y_sum;
    logic [8:0] w_y_end;

    // 9-bit sums so x0+w never wraps before the clamp.
    assign w_x_sum = {1'b0, i_x0} + {1'b0, i_w};
    assign w_y_sum = {1'b0, i_y0} + {1'b0, i_h};
    assign w_x_end = (w_x_sum > W_LIM) ? W_LIM : w_x_sum;
    assign w_y_end = (w_y_sum > H_LIM) ? H_LIM : w_y_sum;

    assign o_w_clip = ({1'b0, i_x0} < W_LIM) ? 8'(w_x_end - {1'b0, i_x0}) : 8'd0;
    assign o_h_clip = ({1'b0, i_y0} < H_LIM) ? 8'(w_y_end - {1'b0, i_y0}) : 8'd0;

    assign o_row_start = FB_ADDR_W'(mul_const(i_y0, vga_pkg::FB_ADDR_W'(FB_WIDTH)))
                       + FB_ADDR_W'(i_x0);

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle-fill engine: accepts one command, clips it, then writes one pixel
// per clock into the framebuffer write port in row-major order.
module fb_rect_fill
    import vga_pkg::*;
#(
    parameter int FB_WIDTH  = vga_pkg::FB_WIDTH,
    parameter int FB_HEIGHT = vga_pkg::FB_HEIGHT,
    parameter int FB_ADDR_W = vga_pkg::FB_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_async,
    // cmd_valid/cmd_ready: a command transfers on a rising edge where both are
    // high; cmd_ready is high only in IDLE, so the fields are read exactly once.
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [7:0]           cmd_x0,
    input  logic [7:0]           cmd_y0,
    input  logic [7:0]           cmd_w,
    input  logic [7:0]           cmd_h,
    input  pixel_t               cmd_color,
    output logic                 busy,
    output logic                 done,
    output logic                 fb_we,
    output logic [FB_ADDR_W-1:0] fb_waddr,
    output pixel_t               fb_wdata,
    output fill_state_t          dbg_state
);

    localparam logic [FB_ADDR_W-1:0] STRIDE = FB_ADDR_W'(FB_WIDTH);

    fill_state_t          r_state;
    logic [7:0]           r_x0;
    logic [7:0]           r_y0;
    logic [7:0]           r_w;
    logic [7:0]           r_h;
    pixel_t               r_color;
    logic [7:0]           r_w_clip;
    logic [7:0]           r_h_clip;
    logic [7:0]           r_col;
    logic [7:0]           r_row;
    logic [FB_ADDR_W-1:0] r_row_start;
    logic [FB_ADDR_W-1:0] r_waddr;
    pixel_t               r_wdata;
    logic                 r_we;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;

    logic [7:0]           w_w_clip;
    logic [7:0]           w_h_clip;
    logic [FB_ADDR_W-1:0] w_row_start;
    logic                 w_last_col;
    logic                 w_last_row;

    fb_clip #(
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT),
        .FB_ADDR_W (FB_ADDR_W)
    ) u_clip (
        .i_x0        (r_x0),
        .i_y0        (r_y0),
        .i_w         (r_w),
        .i_h         (r_h),
        .o_w_clip    (w_w_clip),
        .o_h_clip    (w_h_clip),
        .o_row_start (w_row_start)
    );

    assign w_last_col = (r_col == r_w_clip - 8'd1);
    assign w_last_row = (r_row == r_h_clip - 8'd1);

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            r_state     <= IDLE;
            r_x0        <= '0;
            r_y0        <= '0;
            r_w         <= '0;
            r_h         <= '0;
            r_color     <= '0;
            r_w_clip    <= '0;
            r_h_clip    <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_row_start <= '0;
            r_waddr     <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd_valid && r_ready) begin
                        r_x0    <= cmd_x0;
                        r_y0    <= cmd_y0;
                        r_w     <= cmd_w;
                        r_h     <= cmd_h;
                        r_color <= cmd_color;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    r_w_clip    <= w_w_clip;
                    r_h_clip    <= w_h_clip;
                    r_row_start <= w_row_start;
                    r_col       <= '0;
                    r_row       <= '0;
                    if (w_w_clip == 8'd0 || w_h_clip == 8'd0) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_we    <= 1'b1;
                        r_waddr <= w_row_start;
                        r_wdata <= r_color;
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    if (w_last_col && w_last_row) begin
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (w_last_col) begin
                        // Next line starts one stride below this line's start.
                        r_col       <= '0;
                        r_row       <= r_row + 8'd1;
                        r_row_start <= r_row_start + STRIDE;
                        r_waddr     <= r_row_start + STRIDE;
                    end else begin
                        r_col   <= r_col + 8'd1;
                        r_waddr <= r_waddr + 1'b1;
                    end
                end
                DONE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign fb_we     = r_we;
    assign fb_waddr  = r_waddr;
    assign fb_wdata  = r_wdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Randomised and directed bench for fb_rect_fill against a pixel-list model
// of the clipped rectangle.
module tb_fb_rect_fill;

    localparam int FB_W = 214;
    localparam int FB_H = 160;

    logic        clk       = 1'b0;
    logic        rst_async = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_x0    = '0;
    logic [7:0]  cmd_y0    = '0;
    logic [7:0]  cmd_w     = '0;
    logic [7:0]  cmd_h     = '0;
    logic [2:0]  cmd_color = '0;
    logic        cmd_ready;
    logic        busy;
    logic        done;
    logic        fb_we;
    logic [15:0] fb_waddr;
    logic [2:0]  fb_wdata;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    fb_rect_fill dut (
        .clk       (clk),
        .rst_async (rst_async),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .busy      (busy),
        .done      (done),
        .fb_we     (fb_we),
        .fb_waddr  (fb_waddr),
        .fb_wdata  (fb_wdata),
        .dbg_state (dbg_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: every on-screen pixel of the rectangle, scanned row-major.
    task automatic build_expected(input int x0, input int y0, input int w, input int h);
        exp_q.delete();
        for (int y = y0; y < y0 + h; y++) begin
            for (int x = x0; x < x0 + w; x++) begin
                if (x < FB_W && y < FB_H) exp_q.push_back(16'(y * FB_W + x));
            end
        end
    endtask

    task automatic scramble_fields();
        cmd_x0    = 8'($urandom);
        cmd_y0    = 8'($urandom);
        cmd_w     = 8'($urandom);
        cmd_h     = 8'($urandom);
        cmd_color = 3'($urandom);
    endtask

    // Called at a falling edge with the engine idle; returns at a falling edge.
    task automatic run_cmd(input int x0, input int y0, input int w, input int h,
                           input int color, input bit hold, input int abort_at);
        int n;
        logic [15:0] exp_addr;
        logic [15:0] last_addr;
        build_expected(x0, y0, w, h);
        n = exp_q.size();
        last_addr = '0;
        cmd_valid = 1'b1;
        cmd_x0    = 8'(x0);
        cmd_y0    = 8'(y0);
        cmd_w     = 8'(w);
        cmd_h     = 8'(h);
        cmd_color = 3'(color);
        check_eq("accept_ready", cmd_ready, 1);
        @(negedge clk);
        check_eq("setup_we", fb_we, 0);
        check_eq("setup_busy", busy, 1);
        check_eq("setup_ready", cmd_ready, 0);
        check_eq("setup_done", done, 0);
        if (hold) scramble_fields();
        else cmd_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            exp_addr = exp_q.pop_front();
            last_addr = exp_addr;
            check_eq("fill_we", fb_we, 1);
            check_eq("fill_addr", fb_waddr, exp_addr);
            check_eq("fill_data", fb_wdata, color);
            check_eq("fill_done", done, 0);
            check_eq("fill_ready", cmd_ready, 0);
            if (hold) scramble_fields();
            if (k == abort_at) begin
                #2 rst_async = 1'b1;
                #1;
                check_eq("abort_we", fb_we, 0);
                check_eq("abort_ready", cmd_ready, 1);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_done", done, 0);
                check_eq("abort_addr", fb_waddr, 0);
                check_eq("abort_data", fb_wdata, 0);
                cmd_valid = 1'b0;
                @(negedge clk);
                rst_async = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check_eq("post_abort_done", done, 0);
                    check_eq("post_abort_we", fb_we, 0);
                    check_eq("post_abort_ready", cmd_ready, 1);
                end
                exp_q.delete();
                return;
            end
        end
        @(negedge clk);
        check_eq("done_pulse", done, 1);
        check_eq("done_we", fb_we, 0);
        check_eq("done_busy", busy, 1);
        check_eq("done_ready", cmd_ready, 0);
        if (n > 0) begin
            check_eq("done_hold_addr", fb_waddr, last_addr);
            check_eq("done_hold_data", fb_wdata, color);
        end
        @(negedge clk);
        check_eq("idle_ready", cmd_ready, 1);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_done", done, 0);
        check_eq("idle_we", fb_we, 0);
        cmd_valid = 1'b0;
    endtask

    initial begin
        // Asynchronous reset, observed before any clock edge.
        #2 rst_async = 1'b1;
        #1;
        check_eq("rst_ready", cmd_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_we", fb_we, 0);
        check_eq("rst_addr", fb_waddr, 0);
        check_eq("rst_data", fb_wdata, 0);
        @(negedge clk);
        rst_async = 1'b0;
        repeat (2) @(negedge clk);

        run_cmd(10, 5, 2, 2, 5, 1'b0, -1);
        run_cmd(212, 158, 5, 5, 2, 1'b0, -1);
        run_cmd(20, 20, 0, 7, 3, 1'b0, -1);
        run_cmd(214, 10, 10, 3, 6, 1'b0, -1);
        run_cmd(5, 160, 4, 4, 1, 1'b0, -1);
        run_cmd(0, 0, 255, 255, 7, 1'b0, -1);
        run_cmd(100, 50, 6, 3, 4, 1'b1, -1);
        run_cmd(30, 40, 4, 4, 6, 1'b0, 2);
        run_cmd(31, 41, 4, 4, 2, 1'b0, -1);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_cmd($urandom_range(0, 223), $urandom_range(0, 167),
                    $urandom_range(0, 12), $urandom_range(0, 12),
                    $urandom_range(0, 7), ($urandom_range(0, 3) == 0), -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
